// File: rtl/module_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a fast path for divide corner cases.
module module_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            abort,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [2*XLEN-1:0]   prod_r, prod_nxt_s, step_s, prod_fix_s;
  logic [XLEN-1:0]     opb_r, res_r, res_nxt_s, fix_res_s, fast_res_s, mag1_s, mag2_s;
  logic [XLEN:0]       add_s, trial_s;
  logic [2:0]          op_r;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic                neg_hi_r, neg_rem_r, ready_r, done_r, done_nxt_s;
  logic                sgn1_s, sgn2_s, accept_s, div0_s, ovf_s, fast_s, load_s;

  function automatic logic [XLEN-1:0] cneg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand signedness, magnitudes and divide corner-case detection at acceptance
  assign sgn1_s     = op1[XLEN-1] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
  assign sgn2_s     = op2[XLEN-1] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
  assign mag1_s     = cneg_x(op1, sgn1_s);
  assign mag2_s     = cneg_x(op2, sgn2_s);
  assign accept_s   = start && ready_r && !abort;
  assign div0_s     = op[2] && (op2 == {XLEN{1'b0}});
  assign ovf_s      = op[2] && !op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
  assign fast_s     = div0_s || ovf_s;
  assign fast_res_s = div0_s ? (op[1] ? op1 : {XLEN{1'b1}}) : (op[1] ? {XLEN{1'b0}} : op1);
  assign load_s     = accept_s && !fast_s;

  // High half holds the partial product/remainder, low half the multiplier/dividend-quotient
  assign add_s      = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
  assign trial_s    = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]} - {1'b0, opb_r};
  assign prod_fix_s = cneg_2x(prod_r, neg_hi_r);

  // One iteration step and the sign-corrected result selection
  always_comb begin
    step_s    = prod_r;
    fix_res_s = res_r;
    if (op_r[2]) begin
      if (trial_s[XLEN]) begin
        step_s = {prod_r[2*XLEN-2:0], 1'b0};
      end else begin
        step_s = {trial_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
      end
    end else begin
      if (prod_r[0]) begin
        step_s = {add_s, prod_r[XLEN-1:1]};
      end else begin
        step_s = {1'b0, prod_r[2*XLEN-1:1]};
      end
    end
    case (op_r)
      3'd0:          fix_res_s = prod_fix_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fix_res_s = cneg_x(prod_r[XLEN-1:0], neg_hi_r);
      3'd6, 3'd7:    fix_res_s = cneg_x(prod_r[2*XLEN-1:XLEN], neg_rem_r);
      default:       fix_res_s = res_r;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt_s = state_r;
    prod_nxt_s  = prod_r;
    cnt_nxt_s   = cnt_r;
    res_nxt_s   = res_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s && fast_s) begin
          state_nxt_s = DONE;
          res_nxt_s   = fast_res_s;
          done_nxt_s  = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = CALC;
          prod_nxt_s  = {{XLEN{1'b0}}, mag1_s};
          cnt_nxt_s   = CW'(XLEN-1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          prod_nxt_s = step_s;
          if (cnt_r == {CW{1'b0}}) begin
            state_nxt_s = FIX;
          end else begin
            cnt_nxt_s = cnt_r - CW'(1);
          end
        end
      end
      FIX: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
          res_nxt_s   = fix_res_s;
          done_nxt_s  = 1'b1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      prod_r    <= {(2*XLEN){1'b0}};
      cnt_r     <= {CW{1'b0}};
      res_r     <= {XLEN{1'b0}};
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
      op_r      <= 3'd0;
      opb_r     <= {XLEN{1'b0}};
      neg_hi_r  <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      prod_r  <= prod_nxt_s;
      cnt_r   <= cnt_nxt_s;
      res_r   <= res_nxt_s;
      done_r  <= done_nxt_s;
      ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == DONE);
      if (load_s) begin
        op_r      <= op;
        opb_r     <= mag2_s;
        neg_hi_r  <= sgn1_s ^ sgn2_s;
        neg_rem_r <= sgn1_s;
      end
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign res   = res_r;

endmodule

// File: tb/tb_module_muldiv.sv
// Directed self-checking bench for module_muldiv at XLEN=32 and XLEN=8.
module tb_module_muldiv;

  logic        clk, reset, start32, start8, abort;
  logic [2:0]  op;
  logic [31:0] op1, op2, res32;
  logic [7:0]  res8;
  logic        ready32, done32, ready8, done8;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] r;
  int          lat;
  bit          ok, saw_done;

  module_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .op1(op1), .op2(op2),
    .abort(abort), .ready(ready32), .done(done32), .res(res32)
  );

  module_muldiv #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .op1(op1[7:0]), .op2(op2[7:0]),
    .abort(abort), .ready(ready8), .done(done8), .res(res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge with operands scrambled
  task automatic issue(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; op1 = a; op2 = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0; start8 = 1'b0;
    op = 3'd7; op1 = 32'hDEAD_BEEF; op2 = 32'h0BAD_F00D;
  endtask

  // Latency counts cycles from the start cycle (0) to the done cycle
  task automatic wait_done(input bit w8, output logic [31:0] rr, output int l, output bit rok);
    l = 0; rr = 32'h0; rok = 1'b1;
    for (int c = 1; c <= 60 && l == 0; c++) begin
      @(negedge clk);
      if (w8 ? done8 : done32) begin
        l  = c;
        rr = w8 ? {24'h0, res8} : res32;
      end else begin
        if (w8 ? ready8 : ready32) rok = 1'b0;
        @(posedge clk);
      end
    end
  endtask

  task automatic run(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] rr, output int l, output bit rok);
    @(negedge clk);
    issue(w8, o, a, b);
    wait_done(w8, rr, l, rok);
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; abort = 1'b0;
    op = 3'd0; op1 = 32'h0; op2 = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready32}, 32'h1);
    chk("rst_done", {31'h0, done32}, 32'h0);
    chk("rst_res", res32, 32'h0);

    run(1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, ok);
    chk("mul_ff", r, 32'h0000_0001);
    chk("mul_lat", lat, 32'd34);
    chk("mul_busy", {31'h0, ok}, 32'h1);
    run(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, ok);
    chk("mulhu_ff", r, 32'hFFFF_FFFE);
    chk("mulhu_lat", lat, 32'd34);
    chk("mulhu_busy", {31'h0, ok}, 32'h1);

    run(1'b0, 3'd1, -32'sd16, -32'sd5, r, lat, ok);
    chk("mulh_neg", r, 32'h0000_0000);
    run(1'b0, 3'd0, -32'sd16, -32'sd5, r, lat, ok);
    chk("mul_neg", r, 32'd80);
    run(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, r, lat, ok);
    chk("mulh_min", r, 32'h4000_0000);
    run(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, r, lat, ok);
    chk("mulhsu", r, 32'hFFFF_FFFF);

    run(1'b0, 3'd4, -32'sd21, 32'd5, r, lat, ok);
    chk("div", r, 32'hFFFF_FFFC);
    chk("div_lat", lat, 32'd34);
    run(1'b0, 3'd6, -32'sd21, 32'd5, r, lat, ok);
    chk("rem", r, 32'hFFFF_FFFF);
    run(1'b0, 3'd5, 32'd21, 32'd5, r, lat, ok);
    chk("divu", r, 32'd4);

    run(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ok);
    chk("rem_ovf", r, 32'h0);
    chk("rem_ovf_lat", lat, 32'd1);
    run(1'b0, 3'd7, 32'h1234, 32'h0, r, lat, ok);
    chk("remu_0", r, 32'h1234);
    chk("remu_0_lat", lat, 32'd1);
    run(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ok);
    chk("div_ovf", r, 32'h8000_0000);
    run(1'b0, 3'd4, 32'h1234, 32'h0, r, lat, ok);
    chk("div_0", r, 32'hFFFF_FFFF);
    chk("div_0_lat", lat, 32'd1);

    // Abort a DIV in flight on cycle 10
    saw_done = 1'b0;
    @(negedge clk);
    issue(1'b0, 3'd4, -32'sd100, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done32) saw_done = 1'b1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'h0, ready32}, 32'h1);
    chk("abort_done", {31'h0, done32 | saw_done}, 32'h0);
    chk("abort_res", res32, 32'hFFFF_FFFF);
    run(1'b0, 3'd0, 32'd7, 32'd6, r, lat, ok);
    chk("mul_after_abort", r, 32'd42);

    // start together with abort in IDLE is refused
    @(negedge clk);
    op = 3'd0; op1 = 32'd3; op2 = 32'd3; start32 = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_ready", {31'h0, ready32}, 32'h1);
    chk("start_abort_done", {31'h0, done32}, 32'h0);

    // Reset mid-CALC
    @(negedge clk);
    issue(1'b0, 3'd0, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'h0, ready32}, 32'h1);
    chk("rstmid_done", {31'h0, done32}, 32'h0);
    chk("rstmid_res", res32, 32'h0);

    // Back-to-back: second start issued in the DONE cycle of the first
    run(1'b0, 3'd5, 32'd100, 32'd7, r, lat, ok);
    chk("b2b_first", r, 32'd14);
    issue(1'b0, 3'd7, 32'd100, 32'd7);
    wait_done(1'b0, r, lat, ok);
    chk("b2b_second", r, 32'd2);
    chk("b2b_lat", lat, 32'd34);

    // XLEN=8 instance
    run(1'b1, 3'd3, 32'hFF, 32'hFF, r, lat, ok);
    chk("x8_mulhu", r, 32'hFE);
    chk("x8_lat", lat, 32'd10);
    issue(1'b1, 3'd0, 32'hFF, 32'hFF);
    wait_done(1'b1, r, lat, ok);
    chk("x8_b2b_mul", r, 32'h01);
    chk("x8_b2b_lat", lat, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
